// File: rtl/icache_refill_controller.sv
// Instruction-cache miss handler: issues one line-aligned burst read per miss,
// forwards the returned words to the cache and discards beats after a flush.
module icache_refill_controller #(
    parameter int DATA_LENGTH = 32,
    parameter int LINE_SIZE   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   miss_detected,
    input  logic [31:0]            miss_addr,
    input  logic                   refill_complete,
    output logic                   refill_valid,
    output logic [DATA_LENGTH-1:0] refill_data,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [31:0]            mem_req_addr,
    input  logic                   mem_resp_valid,
    input  logic [DATA_LENGTH-1:0] mem_resp_data,
    output logic                   busy,
    output logic                   fetch_stall,
    output logic                   proto_err
);

    localparam int WORDS_PER_LINE    = LINE_SIZE / (DATA_LENGTH / 8);
    localparam int BLOCK_OFFSET_BITS = $clog2(LINE_SIZE);
    localparam int CNT_W             = $clog2(WORDS_PER_LINE) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        WAIT_DONE,
        DRAIN,
        RESUME
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       beat_cnt_reg, beat_cnt_next;
    logic                   flush_pend_reg, flush_pend_next;
    logic [31:0]            addr_reg, addr_next;
    logic                   refill_valid_reg, refill_valid_next;
    logic [DATA_LENGTH-1:0] refill_data_reg, refill_data_next;
    logic                   proto_err_reg, proto_err_next;
    logic [31:0]            aligned_addr;

    assign aligned_addr = {miss_addr[31:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            beat_cnt_reg     <= '0;
            flush_pend_reg   <= 1'b0;
            addr_reg         <= '0;
            refill_valid_reg <= 1'b0;
            refill_data_reg  <= '0;
            proto_err_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            beat_cnt_reg     <= beat_cnt_next;
            flush_pend_reg   <= flush_pend_next;
            addr_reg         <= addr_next;
            refill_valid_reg <= refill_valid_next;
            refill_data_reg  <= refill_data_next;
            proto_err_reg    <= proto_err_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        beat_cnt_next     = beat_cnt_reg;
        flush_pend_next   = flush_pend_reg;
        addr_next         = addr_reg;
        refill_valid_next = 1'b0;
        refill_data_next  = refill_data_reg;
        proto_err_next    = proto_err_reg;

        case (state_reg)
            IDLE: begin
                if (miss_detected && !flush) begin
                    addr_next  = aligned_addr;
                    state_next = REQ;
                end
            end

            REQ: begin
                if (flush) begin
                    flush_pend_next = 1'b1;
                end
                if (mem_req_ready) begin
                    beat_cnt_next = '0;
                    state_next    = (flush_pend_reg || flush) ? DRAIN : FILL;
                end
            end

            FILL: begin
                if (mem_resp_valid) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                    if (!flush) begin
                        refill_valid_next = 1'b1;
                        refill_data_next  = mem_resp_data;
                    end
                end
                if (flush) begin
                    // A flush that coincides with the final beat has nothing left to drain.
                    if (mem_resp_valid && beat_cnt_reg == LAST_BEAT) begin
                        flush_pend_next = 1'b0;
                        state_next      = IDLE;
                    end else begin
                        flush_pend_next = 1'b1;
                        state_next      = DRAIN;
                    end
                end else if (mem_resp_valid && beat_cnt_reg == LAST_BEAT) begin
                    state_next = WAIT_DONE;
                end
            end

            DRAIN: begin
                if (mem_resp_valid) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                    if (beat_cnt_reg == LAST_BEAT) begin
                        flush_pend_next = 1'b0;
                        state_next      = IDLE;
                    end
                end
            end

            WAIT_DONE: begin
                if (refill_complete) begin
                    state_next = RESUME;
                end else if (flush) begin
                    state_next = IDLE;
                end
            end

            RESUME: begin
                // The cache's registered miss flag is still stale here, so it is ignored.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (mem_resp_valid && state_reg != FILL && state_reg != DRAIN) begin
            proto_err_next = 1'b1;
        end
    end

    assign refill_valid  = refill_valid_reg;
    assign refill_data   = refill_data_reg;
    assign mem_req_valid = (state_reg == REQ);
    assign mem_req_addr  = addr_reg;
    assign busy          = (state_reg != IDLE);
    assign fetch_stall   = busy | miss_detected;
    assign proto_err     = proto_err_reg;

endmodule
